// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: round-robin arbitrating merge of SIZE valid/ready input
// channels into one registered output slot. Each cycle one requester is
// granted in rotating priority order. The winning payload and its channel
// number are captured into a one-entry output buffer.
module rr_arbiter_n #(
    parameter int SIZE        = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SIZE*DATA_WIDTH-1:0]   ins,
    input  logic [SIZE-1:0]              ins_valid,
    output logic [SIZE-1:0]              ins_ready,
    output logic [DATA_WIDTH-1:0]        outs,
    output logic                         outs_valid,
    input  logic                         outs_ready,
    output logic [INDEX_WIDTH-1:0]       index
);

    // Highest-priority channel for the next arbitration.
    logic [INDEX_WIDTH-1:0] ptr;

    logic                   any_req;
    logic                   slot_free;
    logic                   load;
    logic [SIZE-1:0]        prio_mask;
    logic [SIZE-1:0]        req_hi;
    logic [INDEX_WIDTH-1:0] grant;
    logic [INDEX_WIDTH-1:0] ptr_next;
    logic [DATA_WIDTH-1:0]  grant_data;

    // Lowest-numbered set bit of a request vector; zero when none is set.
    function automatic logic [INDEX_WIDTH-1:0] lowest_set(input logic [SIZE-1:0] vec);
        logic [INDEX_WIDTH-1:0] idx;
        idx = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (vec[i]) idx = INDEX_WIDTH'(i);
        end
        return idx;
    endfunction

    assign any_req   = |ins_valid;
    assign slot_free = !outs_valid || outs_ready;
    assign load      = any_req && slot_free;

    // Thermometer mask selecting channels at or above the pointer.
    // NOTE: every signal driven in always_comb gets a default first so that no
    // path through the block leaves it unassigned and a latch is never inferred.
    always_comb begin
        prio_mask = '0;
        for (int i = 0; i < SIZE; i++) begin
            prio_mask[i] = (INDEX_WIDTH'(i) >= ptr);
        end
    end

    // Rotating priority: the lowest requester at/after ptr wins; if none, wrap
    // around and take the lowest requester below ptr.
    always_comb begin
        req_hi = ins_valid & prio_mask;
        grant  = (|req_hi) ? lowest_set(req_hi) : lowest_set(ins_valid);
    end

    // Pointer moves just past the winner, wrapping from SIZE-1 back to 0.
    always_comb begin
        ptr_next = grant + INDEX_WIDTH'(1);
        if (grant == INDEX_WIDTH'(SIZE - 1)) ptr_next = '0;
    end

    // Payload of the granted channel.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (grant == INDEX_WIDTH'(i)) grant_data = ins[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // One-hot ready toward the winner, only when the slot can take a token.
    always_comb begin
        ins_ready = '0;
        for (int i = 0; i < SIZE; i++) begin
            ins_ready[i] = load && (grant == INDEX_WIDTH'(i));
        end
    end

    // Output slot and pointer: load the winner, or drain when nothing competes.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    // NOTE: the slot payload is reset as well, since a cleared outs/index is
    // observable after reset rather than a don't-care storage array.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr        <= '0;
            outs       <= '0;
            index      <= '0;
            outs_valid <= 1'b0;
        end else if (load) begin
            outs       <= grant_data;
            index      <= grant;
            outs_valid <= 1'b1;
            ptr        <= ptr_next;
        end else if (outs_ready) begin
            outs_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_n.sv
// tb_rr_arbiter_n: directed bench for rr_arbiter_n. Two instances are
// exercised (SIZE=4 and SIZE=3 with a 2-bit index). A behavioural model
// scans requesters from the pointer and predicts every output each cycle.
// Hand-computed literals pin the expected grant sequences.
module tb_rr_arbiter_n;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: SIZE=4
    logic [4*DW-1:0] a_ins;
    logic [3:0]      a_valid;
    logic [3:0]      a_ready;
    logic [DW-1:0]   a_outs;
    logic            a_ovalid;
    logic            a_oready;
    logic [1:0]      a_index;

    // Instance B: SIZE=3, INDEX_WIDTH=2
    logic [3*DW-1:0] b_ins;
    logic [2:0]      b_valid;
    logic [2:0]      b_ready;
    logic [DW-1:0]   b_outs;
    logic            b_ovalid;
    logic            b_oready;
    logic [1:0]      b_index;

    rr_arbiter_n #(.SIZE(4), .DATA_WIDTH(DW), .INDEX_WIDTH(2)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .ins        (a_ins),
        .ins_valid  (a_valid),
        .ins_ready  (a_ready),
        .outs       (a_outs),
        .outs_valid (a_ovalid),
        .outs_ready (a_oready),
        .index      (a_index)
    );

    rr_arbiter_n #(.SIZE(3), .DATA_WIDTH(DW), .INDEX_WIDTH(2)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .ins        (b_ins),
        .ins_valid  (b_valid),
        .ins_ready  (b_ready),
        .outs       (b_outs),
        .outs_valid (b_ovalid),
        .outs_ready (b_oready),
        .index      (b_index)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // First requesting channel scanning ptr, ptr+1, ... modulo n; -1 if none.
    function automatic int rr_pick(input logic [3:0] v, input int ptr, input int n);
        for (int k = 0; k < n; k++) begin
            int c;
            c = (ptr + k) % n;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready(input logic [3:0] v, input int ptr,
                                             input logic full, input logic oready, input int n);
        int g;
        g = rr_pick(v, ptr, n);
        if (g >= 0 && (!full || oready)) return 4'(1 << g);
        return 4'b0;
    endfunction

    // Reference state for instance A
    int            ma_ptr  = 0;
    logic          ma_v    = 1'b0;
    logic [DW-1:0] ma_outs = '0;
    int            ma_idx  = 0;

    // Reference state for instance B
    int            mb_ptr  = 0;
    logic          mb_v    = 1'b0;
    logic [DW-1:0] mb_outs = '0;
    int            mb_idx  = 0;

    // Reference model update for instance A
    always @(posedge clk or negedge rst) begin
        int g;
        if (!rst) begin
            ma_ptr = 0; ma_v = 1'b0; ma_outs = '0; ma_idx = 0;
        end else begin
            g = rr_pick(a_valid, ma_ptr, 4);
            if (g >= 0 && (!ma_v || a_oready)) begin
                ma_outs = a_ins[g*DW +: DW];
                ma_idx  = g;
                ma_v    = 1'b1;
                ma_ptr  = (g + 1) % 4;
            end else if (ma_v && a_oready) begin
                ma_v = 1'b0;
            end
        end
    end

    // Reference model update for instance B
    always @(posedge clk or negedge rst) begin
        int g;
        if (!rst) begin
            mb_ptr = 0; mb_v = 1'b0; mb_outs = '0; mb_idx = 0;
        end else begin
            g = rr_pick({1'b0, b_valid}, mb_ptr, 3);
            if (g >= 0 && (!mb_v || b_oready)) begin
                mb_outs = b_ins[g*DW +: DW];
                mb_idx  = g;
                mb_v    = 1'b1;
                mb_ptr  = (g + 1) % 3;
            end else if (mb_v && b_oready) begin
                mb_v = 1'b0;
            end
        end
    end

    // Compare both instances against the model every cycle, away from the edge.
    always @(negedge clk) begin
        check("a_ins_ready", a_ready, exp_ready(a_valid, ma_ptr, ma_v, a_oready, 4));
        check("a_outs_valid", a_ovalid, ma_v);
        check("a_outs", a_outs, ma_outs);
        check("a_index", a_index, ma_idx);
        check("b_ins_ready", b_ready, 3'(exp_ready({1'b0, b_valid}, mb_ptr, mb_v, b_oready, 3)));
        check("b_outs_valid", b_ovalid, mb_v);
        check("b_outs", b_outs, mb_outs);
        check("b_index", b_index, mb_idx);
        check("b_index_range", b_index < 2'd3, 1);
    end

    initial begin
        a_ins = '0; a_valid = '0; a_oready = 1'b0;
        b_ins = '0; b_valid = '0; b_oready = 1'b0;
        #1 rst = 1'b0;
        repeat (3) tick();
        check("rst_a_ovalid", a_ovalid, 0);
        check("rst_a_outs", a_outs, 0);
        check("rst_a_index", a_index, 0);
        check("rst_a_ready", a_ready, 0);
        rst = 1'b1;
        tick();

        // Fairness: all four channels valid, downstream always ready.
        for (int i = 0; i < 4; i++) a_ins[i*DW +: DW] = 8'hA0 + 8'(i);
        a_valid  = 4'hF;
        a_oready = 1'b1;
        #1 check("fair_ready_first", a_ready, 4'b0001);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("fair_index", a_index, i % 4);
            check("fair_outs", a_outs, 8'hA0 + (i % 4));
            check("fair_ovalid", a_ovalid, 1);
        end

        // Skip idle requesters: ptr back at 0, only channels 1 and 3 request.
        a_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("skip_index", a_index, (i % 2 == 1) ? 3 : 1);
            check("skip_outs", a_outs, (i % 2 == 1) ? 8'hA3 : 8'hA1);
        end
        a_valid = 4'b0001;
        tick();
        check("skip_ch0_index", a_index, 0);
        check("skip_ch0_outs", a_outs, 8'hA0);

        // Backpressure: load channel 2 with 0x55, then stall for 4 cycles.
        a_ins[2*DW +: DW] = 8'h55;
        a_valid = 4'b0100;
        tick();
        check("bp_load_index", a_index, 2);
        check("bp_load_outs", a_outs, 8'h55);
        a_ins[3*DW +: DW] = 8'hB3;
        a_oready = 1'b0;
        a_valid  = 4'hF;
        for (int i = 0; i < 4; i++) begin
            #1 check("bp_hold_ready", a_ready, 4'b0000);
            tick();
            check("bp_hold_outs", a_outs, 8'h55);
            check("bp_hold_index", a_index, 2);
            check("bp_hold_ovalid", a_ovalid, 1);
        end
        a_oready = 1'b1;
        #1 check("bp_release_ready", a_ready, 4'b1000);
        tick();
        check("bp_next_index", a_index, 3);
        check("bp_next_outs", a_outs, 8'hB3);

        // Drain without refill: slot empties, payload and index hold.
        a_valid = 4'b0000;
        tick();
        check("drain_ovalid", a_ovalid, 0);
        check("drain_index", a_index, 3);
        check("drain_outs", a_outs, 8'hB3);
        tick();
        check("drain_hold_outs", a_outs, 8'hB3);

        // Reset mid-cycle with a token held in the slot.
        a_valid = 4'b0001;
        tick();
        a_valid  = 4'b0000;
        a_oready = 1'b0;
        check("mid_full_ovalid", a_ovalid, 1);
        #3 rst = 1'b0;
        #1 check("mid_rst_ovalid", a_ovalid, 0);
        check("mid_rst_outs", a_outs, 0);
        check("mid_rst_index", a_index, 0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_ovalid", a_ovalid, 0);
            check("idle_ready", a_ready, 0);
            check("idle_outs", a_outs, 0);
            check("idle_index", a_index, 0);
        end
        a_valid  = 4'hF;
        a_oready = 1'b1;
        #1 check("post_rst_ptr_ready", a_ready, 4'b0001);
        tick();
        check("post_rst_index", a_index, 0);
        a_valid = 4'b0000;
        tick();

        // Wrap-around on SIZE=3: bring ptr to 2, then channels 0 and 2 compete.
        for (int i = 0; i < 3; i++) b_ins[i*DW +: DW] = 8'hC0 + 8'(i);
        b_oready = 1'b1;
        b_valid  = 3'b010;
        tick();
        check("wrap_ch1_index", b_index, 1);
        b_valid = 3'b101;
        #1 check("wrap_ready_ch2", b_ready, 3'b100);
        tick();
        check("wrap_g2_index", b_index, 2);
        check("wrap_g2_outs", b_outs, 8'hC2);
        check("wrap_ready_ch0", b_ready, 3'b001);
        tick();
        check("wrap_g0_index", b_index, 0);
        check("wrap_g0_outs", b_outs, 8'hC0);
        tick();
        check("wrap_g2b_index", b_index, 2);
        b_valid = 3'b000;
        tick();
        check("wrap_drain_ovalid", b_ovalid, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
